alu_req_arbiter: RTL and testbench
==================================

Name: alu_req_arbiter

Overview:
- Shares the single 32-bit combinational ALU (ops AND/OR/ADD/SUB/SLT/DIV/NOP/MUL, 3-bit opcode, ZF flag) between two requesters.
- Uses a round-robin grant and valid/ready handshakes on both the request and response sides.
- Latches the operands, drives the ALU for a fixed per-op latency, registers the result and flag, and holds them until the response is accepted.
- Sits between the instruction-issue logic and the ALU in the datapath.

Parameters:
- MULDIV_LAT, 4, cycles in EXEC for opcodes 3'b101 (DIV) and 3'b111 (MUL); legal range 1..15.
- W, 32, operand/result width; must match the ALU.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  synchronous active-low reset.
- REQ_VALID  in  2  bit i = requester i has a request.
- REQ_READY  out  2  bit i = request i accepted this cycle (one-hot or zero).
- REQ_OP1  in  2*W  requester i operand 1 in bits [i*W +: W].
- REQ_OP2  in  2*W  requester i operand 2, same packing.
- REQ_OP  in  6  requester i opcode in bits [i*3 +: 3].
- ALU_OP1  out  W  to ALU OP1.
- ALU_OP2  out  W  to ALU OP2.
- ALU_OP  out  3  to ALU OP.
- ALU_OPS  in  W  from ALU OPS.
- ALU_ZF  in  1  from ALU ZF.
- RSP_VALID  out  1  response valid.
- RSP_READY  in  1  response consumer ready.
- RSP_ID  out  1  requester index that owns the response.
- RSP_DATA  out  W  result.
- RSP_ZF  out  1  zero flag of the result.
- RSP_ERR  out  1  error flag (see Optional Feature).

Behaviour:
- Interface: one clock, CLK. Reset RST_N is synchronous and active-low.
- Reset (RST_N=0 at a CLK edge) values:
  - state=IDLE; all outputs 0 (REQ_READY=0, RSP_VALID=0, RSP_DATA=0, RSP_ZF=0, RSP_ERR=0, RSP_ID=0, ALU_OP1/OP2/OP=0).
  - Round-robin pointer=0, meaning requester 0 has priority first.
  - Reset mid-operation aborts any in-flight op; no response is produced for it.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any REQ_VALID bit is set, grant one requester: a lone requester wins; if both are valid, the requester the pointer favours wins.
  - REQ_READY for the winner is combinational in IDLE only.
  - On that edge: latch OP1/OP2/OP/ID, load cnt = (OP is 101 or 111) ? MULDIV_LAT-1 : 0, flip the pointer to the non-winner, go to EXEC.
- EXEC:
  - ALU_OP1/OP2/OP are driven from the latched registers and held stable for the whole state.
  - cnt decrements each cycle. When cnt==0: capture ALU_OPS into RSP_DATA and ALU_ZF into RSP_ZF, set RSP_VALID, go to RESP.
  - Request-to-RSP_VALID latency: 2 cycles for single-cycle ops, MULDIV_LAT+1 cycles for DIV/MUL.
- RESP:
  - RSP_* outputs are held stable while RSP_VALID=1 and RSP_READY=0.
  - On RSP_VALID && RSP_READY: clear RSP_VALID, go to IDLE.
  - A new grant happens no earlier than the cycle after the handshake, so there is one idle cycle between ops.
- NOP (3'b110): RSP_DATA=0 and RSP_ZF=1 are forced (ALU output ignored); latency 2.
- REQ_READY is 0 outside IDLE. Requesters must hold REQ_VALID and operands stable until their REQ_READY is seen.
- Widths: there is no width extension or truncation; values are passed through at W bits.
- Starvation bound: with both requesters always valid, grants strictly alternate 0,1,0,1…

Optional Feature:
- Macro ALU_DIVZERO_CHECK_EN.
- Defined: a DIV (3'b101) with latched OP2==0 skips the ALU result and the multi-cycle wait (cnt forced to 0). Response: RSP_DATA=32'hFFFF_FFFF, RSP_ZF=0, RSP_ERR=1, latency 2. RSP_ERR=0 for every other op.
- Undefined: RSP_ERR is tied 0, and a divide-by-zero is passed to the ALU like any other DIV with the normal MULDIV_LAT timing; its result is unspecified.

Decomposition:
- Shared package alu_pkg holds:
  - Opcode localparams OP_AND=3'b000, OP_OR=3'b001, OP_ADD=3'b010, OP_SUB=3'b011, OP_SLT=3'b100, OP_DIV=3'b101, OP_NOP=3'b110, OP_MUL=3'b111.
  - FSM state encoding ST_IDLE/ST_EXEC/ST_RESP.
  - W default.
- One natural sub-module: rr_arb2, a 2-way round-robin arbiter (inputs req[1:0], advance; outputs grant[1:0], pointer register).
- Latency counter and response registers stay in the top module.

Test Plan:
- Single ADD, requester 0: OP1=5, OP2=7, OP=010 -> REQ_READY=01 in cycle 0; RSP_VALID in cycle 2 with RSP_DATA=12, RSP_ZF=0, RSP_ID=0.
- Contention after reset: both valid; req0 SUB 9-9, req1 OR 0x0F|0xF0 -> req0 first (RSP_DATA=0, RSP_ZF=1), then req1 (RSP_DATA=0xFF); a third pair grants req0 again (alternation).
- MUL, MULDIV_LAT=4: 6*7 -> RSP_VALID exactly 5 cycles after acceptance, RSP_DATA=42; ALU_OP1/OP2/OP are stable throughout EXEC.
- Backpressure: RSP_READY=0 for 3 cycles after RSP_VALID -> RSP_DATA/ID/ZF held and REQ_READY stays 00 despite a pending req1; req1 is granted the cycle after RSP_READY=1.
- Reset mid-op: RST_N=0 during EXEC of a DIV -> next cycle state IDLE with all outputs 0; no RSP_VALID follows.
- Macro defined: DIV 100/0 -> RSP_DATA=0xFFFFFFFF, RSP_ERR=1, latency 2. DIV 100/4 -> RSP_DATA=25, RSP_ERR=0, latency MULDIV_LAT+1.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, FSM encoding and width for the ALU request arbiter
package alu_pkg;

  localparam int W = 32;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b100;
  localparam logic [2:0] OP_DIV = 3'b101;
  localparam logic [2:0] OP_NOP = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // DIV and MUL are the only opcodes that need the multi-cycle wait
  function automatic logic is_muldiv(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_MUL);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter with a one-bit priority pointer
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  // ptr == 0: requester 0 wins a tie; ptr == 1: requester 1 wins a tie
  logic ptr;

  // lone requester always wins; on a tie the pointer decides
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  // after a grant the pointer favours the requester that lost
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (advance && (grant != 2'b00)) begin
      ptr <= grant[0];
    end
  end

endmodule

// File: rtl/alu_req_arbiter.sv
// rtl/alu_req_arbiter.sv - shares one ALU between two requesters; optional macro ALU_DIVZERO_CHECK_EN
module alu_req_arbiter
  import alu_pkg::*;
#(
  parameter int MULDIV_LAT = 4,
  parameter int W          = alu_pkg::W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [2*W-1:0] req_op1,
  input  logic [2*W-1:0] req_op2,
  input  logic [5:0]   req_op,
  output logic [W-1:0] alu_op1,
  output logic [W-1:0] alu_op2,
  output logic [2:0]   alu_op,
  input  logic [W-1:0] alu_ops,
  input  logic         alu_zf,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_data,
  output logic         rsp_zf,
  output logic         rsp_err
);

  state_t       state, state_nxt;
  logic [1:0]   grant;
  logic         advance;

  logic         win_id;
  logic [W-1:0] win_op1, win_op2;
  logic [2:0]   win_op;
  logic         win_dz;

  logic [W-1:0] lat_op1, lat_op2;
  logic [2:0]   lat_op;
  logic         lat_id;
  logic         lat_dz;
  logic [3:0]   cnt;
  logic         exec_done;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_valid),
    .advance (advance),
    .grant   (grant)
  );

  assign win_id  = grant[1];
  assign win_op1 = win_id ? req_op1[2*W-1:W] : req_op1[W-1:0];
  assign win_op2 = win_id ? req_op2[2*W-1:W] : req_op2[W-1:0];
  assign win_op  = win_id ? req_op[5:3]      : req_op[2:0];

`ifdef ALU_DIVZERO_CHECK_EN
  // divide-by-zero is answered locally instead of waiting on the ALU
  assign win_dz = (win_op == OP_DIV) && (win_op2 == '0);
  assign lat_dz = (lat_op == OP_DIV) && (lat_op2 == '0);
`else
  assign win_dz = 1'b0;
  assign lat_dz = 1'b0;
`endif

  // the ALU sees only the latched operands, so it is stable through EXEC
  assign alu_op1   = lat_op1;
  assign alu_op2   = lat_op2;
  assign alu_op    = lat_op;
  assign exec_done = (state == ST_EXEC) && (cnt == 4'd0);

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state logic; request grants are only offered while idle
  always_comb begin
    state_nxt = state;
    req_ready = 2'b00;
    advance   = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = grant;
        if (req_valid != 2'b00) begin
          advance   = 1'b1;
          state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cnt == 4'd0) begin
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // operand latch, latency counter and response registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lat_op1   <= '0;
      lat_op2   <= '0;
      lat_op    <= 3'b000;
      lat_id    <= 1'b0;
      cnt       <= 4'd0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
      rsp_zf    <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      if (advance) begin
        lat_op1 <= win_op1;
        lat_op2 <= win_op2;
        lat_op  <= win_op;
        lat_id  <= win_id;
        cnt     <= (is_muldiv(win_op) && !win_dz) ? 4'(MULDIV_LAT - 1) : 4'd0;
      end else if ((state == ST_EXEC) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end

      if (exec_done) begin
        rsp_valid <= 1'b1;
        rsp_id    <= lat_id;
        if (lat_dz) begin
          rsp_data <= '1;
          rsp_zf   <= 1'b0;
          rsp_err  <= 1'b1;
        end else if (lat_op == OP_NOP) begin
          rsp_data <= '0;
          rsp_zf   <= 1'b1;
          rsp_err  <= 1'b0;
        end else begin
          rsp_data <= alu_ops;
          rsp_zf   <= alu_zf;
          rsp_err  <= 1'b0;
        end
      end else if ((state == ST_RESP) && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// tb/tb_alu_req_arbiter.sv - directed scoreboard bench for alu_req_arbiter
module tb_alu_req_arbiter;
  import alu_pkg::*;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_op1, req_op2;
  logic [5:0]  req_op;
  logic [31:0] alu_op1, alu_op2, alu_ops;
  logic [2:0]  alu_op;
  logic        alu_zf;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_zf, rsp_err;
  logic [31:0] rsp_data;

  always #5 clk = ~clk;

  alu_req_arbiter #(.MULDIV_LAT(LAT), .W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op1(req_op1), .req_op2(req_op2), .req_op(req_op),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_op(alu_op),
    .alu_ops(alu_ops), .alu_zf(alu_zf),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_zf(rsp_zf), .rsp_err(rsp_err)
  );

  // behavioural ALU; NOP deliberately returns junk so forcing is visible
  always_comb begin
    alu_ops = '0;
    case (alu_op)
      OP_AND:  alu_ops = alu_op1 & alu_op2;
      OP_OR:   alu_ops = alu_op1 | alu_op2;
      OP_ADD:  alu_ops = alu_op1 + alu_op2;
      OP_SUB:  alu_ops = alu_op1 - alu_op2;
      OP_SLT:  alu_ops = ($signed(alu_op1) < $signed(alu_op2)) ? 32'd1 : 32'd0;
      OP_DIV:  alu_ops = (alu_op2 == 32'd0) ? 32'hDEAD_BEEF : alu_op1 / alu_op2;
      OP_NOP:  alu_ops = 32'h1234_5678;
      default: alu_ops = alu_op1 * alu_op2;
    endcase
    alu_zf = (alu_ops == 32'd0);
  end

  typedef struct packed {
    logic        id;
    logic [31:0] data;
    logic        zf;
    logic        err;
  } rsp_t;

  rsp_t        exp_q[$];
  int          n_vec = 0;
  int          n_mis = 0;
  logic [2:0]  s_op[2];
  logic [31:0] s_a[2], s_b[2];
  logic [2:0]  cur_op;
  logic [31:0] cur_a, cur_b;
  int          cur_lat;

  function automatic rsp_t model(input logic id, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    rsp_t r;
    r.id  = id;
    r.err = 1'b0;
    case (op)
      OP_AND:  r.data = a & b;
      OP_OR:   r.data = a | b;
      OP_ADD:  r.data = a + b;
      OP_SUB:  r.data = a - b;
      OP_SLT:  r.data = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_DIV:  r.data = (b == 32'd0) ? 32'hDEAD_BEEF : a / b;
      OP_NOP:  r.data = 32'd0;
      default: r.data = a * b;
    endcase
    r.zf = (r.data == 32'd0);
`ifdef ALU_DIVZERO_CHECK_EN
    if (op == OP_DIV && b == 32'd0) begin
      r.data = 32'hFFFF_FFFF;
      r.zf   = 1'b0;
      r.err  = 1'b1;
    end
`endif
    return r;
  endfunction

  function automatic int lat_of(input logic [2:0] op, input logic [31:0] b);
`ifdef ALU_DIVZERO_CHECK_EN
    if (op == OP_DIV && b == 32'd0) return 2;
`endif
    if (op == OP_DIV || op == OP_MUL) return LAT + 1;
    return 2;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int id, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    s_op[id] = op;
    s_a[id]  = a;
    s_b[id]  = b;
    req_op1[id*32 +: 32] = a;
    req_op2[id*32 +: 32] = b;
    req_op[id*3 +: 3]    = op;
    req_valid[id]        = 1'b1;
  endtask

  // waits for a grant, checks who won, records the expected response
  task automatic wait_grant(input logic [1:0] exp, input string tag, output int waited);
    int gid;
    logic hit;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (req_ready == 2'b00 && waited < 50);
    chk({tag, "_grant"}, 64'(req_ready), 64'(exp));
    hit = (req_ready != 2'b00);
    gid = req_ready[1] ? 1 : 0;
    if (hit) begin
      exp_q.push_back(model(gid[0], s_op[gid], s_a[gid], s_b[gid]));
      cur_op  = s_op[gid];
      cur_a   = s_a[gid];
      cur_b   = s_b[gid];
      cur_lat = lat_of(s_op[gid], s_b[gid]);
    end
    @(posedge clk);
    #1;
    if (hit) req_valid[gid] = 1'b0;
  endtask

  // counts cycles from grant to rsp_valid, checking ALU inputs meanwhile
  task automatic wait_rsp(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (rsp_valid !== 1'b1) begin
        chk({tag, "_alu_op1"}, 64'(alu_op1), 64'(cur_a));
        chk({tag, "_alu_op2"}, 64'(alu_op2), 64'(cur_b));
        chk({tag, "_alu_op"},  64'(alu_op),  64'(cur_op));
      end
    end while (rsp_valid !== 1'b1 && n < 60);
    chk({tag, "_latency"}, 64'(n), 64'(cur_lat));
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_rsp_data"},  64'(rsp_data),  64'd0);
    chk({tag, "_rsp_zf"},    64'(rsp_zf),    64'd0);
    chk({tag, "_rsp_err"},   64'(rsp_err),   64'd0);
    chk({tag, "_rsp_id"},    64'(rsp_id),    64'd0);
    chk({tag, "_alu_op1"},   64'(alu_op1),   64'd0);
    chk({tag, "_alu_op2"},   64'(alu_op2),   64'd0);
    chk({tag, "_alu_op"},    64'(alu_op),    64'd0);
  endtask

  // scoreboard: every accepted response is popped and compared
  always @(negedge clk) begin
    if (rst_n === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      rsp_t e;
      chk("rsp_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("rsp_id",   64'(rsp_id),   64'(e.id));
        chk("rsp_data", 64'(rsp_data), 64'(e.data));
        chk("rsp_zf",   64'(rsp_zf),   64'(e.zf));
        chk("rsp_err",  64'(rsp_err),  64'(e.err));
      end
    end
  end

  logic [2:0]  t_op[8] = '{OP_ADD, OP_SLT, OP_SLT, OP_AND, OP_NOP, OP_DIV, OP_MUL, OP_SUB};
  logic [31:0] t_a[8]  = '{32'd5, 32'hFFFF_FFFF, 32'd1, 32'hFF00_FF00, 32'd3, 32'd100, 32'd6, 32'd3};
  logic [31:0] t_b[8]  = '{32'd7, 32'd1, 32'hFFFF_FFFF, 32'h0FF0_0FF0, 32'd4, 32'd4, 32'd7, 32'd5};

  initial begin
    int w;
    int seen;
    rst_n     = 1'b0;
    req_valid = 2'b00;
    req_op1   = '0;
    req_op2   = '0;
    req_op    = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // single ops from alternating requesters
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      drive(i % 2, t_op[i], t_a[i], t_b[i]);
      wait_grant((i % 2 == 0) ? 2'b01 : 2'b10, $sformatf("single%0d", i), w);
      chk($sformatf("single%0d_wait", i), 64'(w), 64'd1);
      wait_rsp($sformatf("single%0d", i));
    end

    // contention: fresh pointer state favours req0, then req1
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive(0, OP_SUB, 32'd9, 32'd9);
    drive(1, OP_OR, 32'h0F, 32'hF0);
    wait_grant(2'b01, "cont0", w);
    wait_rsp("cont0");
    wait_grant(2'b10, "cont1", w);
    chk("cont1_gap", 64'(w), 64'd1);
    wait_rsp("cont1");

    // both kept valid: grants alternate 0,1,0
    @(posedge clk);
    #1;
    drive(0, OP_AND, 32'hF0F0, 32'h0FF0);
    drive(1, OP_ADD, 32'd100, 32'd23);
    wait_grant(2'b01, "alt0", w);
    drive(0, OP_ADD, 32'hFFFF_FFFF, 32'd1);
    wait_rsp("alt0");
    wait_grant(2'b10, "alt1", w);
    wait_rsp("alt1");
    wait_grant(2'b01, "alt2", w);
    wait_rsp("alt2");

    // backpressure holds the response and blocks new grants
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    drive(0, OP_AND, 32'hFF00_FF00, 32'h0FF0_0FF0);
    wait_grant(2'b01, "bp0", w);
    drive(1, OP_ADD, 32'd1, 32'd2);
    wait_rsp("bp0");
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      chk("bp_hold_valid", 64'(rsp_valid), 64'd1);
      chk("bp_hold_data",  64'(rsp_data),  64'h0F00_0F00);
      chk("bp_hold_id",    64'(rsp_id),    64'd0);
      chk("bp_hold_zf",    64'(rsp_zf),    64'd0);
      chk("bp_req_ready",  64'(req_ready), 64'd0);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    wait_grant(2'b10, "bp1", w);
    chk("bp1_wait", 64'(w), 64'd2);
    wait_rsp("bp1");

    // reset during a DIV aborts it and restores the pointer
    @(posedge clk);
    #1;
    drive(0, OP_DIV, 32'd100, 32'd4);
    wait_grant(2'b01, "mid", w);
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check_idle_outputs("midrst");
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) seen++;
    end
    chk("midrst_no_rsp", 64'(seen), 64'd0);
    @(posedge clk);
    #1;
    drive(0, OP_ADD, 32'd2, 32'd2);
    drive(1, OP_ADD, 32'd3, 32'd3);
    wait_grant(2'b01, "post0", w);
    wait_rsp("post0");
    wait_grant(2'b10, "post1", w);
    wait_rsp("post1");

    // divide checks; the zero divisor case only exists with the check enabled
    @(posedge clk);
    #1;
    drive(1, OP_DIV, 32'd100, 32'd4);
    wait_grant(2'b10, "div", w);
    wait_rsp("div");
`ifdef ALU_DIVZERO_CHECK_EN
    @(posedge clk);
    #1;
    drive(0, OP_DIV, 32'd100, 32'd0);
    wait_grant(2'b01, "divz", w);
    wait_rsp("divz");
`endif

    @(posedge clk);
    @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
